// File: rtl/div_pkg.sv
// Shared types and constants for the 64/32 iterative restoring divider.
// Widths are fixed so the divider pairs directly with the 32x32 multiplier.
package div_pkg;

  localparam int DIV_ITER = 32;
  localparam int DVD_W    = 64;
  localparam int DVS_W    = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  localparam logic [DVS_W-1:0] Q_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_DBZ  = 2'd1,
    EXC_OVF  = 2'd2
  } exc_t;

  // Zero divisor is tested first: a zero divisor would also satisfy the
  // high-word overflow test, and the two flags must never both be raised.
  function automatic exc_t classify(input logic [DVD_W-1:0] dvd,
                                    input logic [DVS_W-1:0] dvs);
    exc_t code;
    if (dvs == '0)
      code = EXC_DBZ;
    else if (dvd[DVD_W-1:DVS_W] >= dvs)
      code = EXC_OVF;
    else
      code = EXC_NONE;
    return code;
  endfunction

endpackage

// File: rtl/div64x32_arith.sv
// Datapath for the divider: partial remainder, quotient shift register,
// the per-cycle compare/subtract and the registered result outputs.
module div64x32_arith
  import div_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic                   commit,
  input  exc_t                   exc_code,
  input  logic [DVD_W-1:0]       dividend,
  input  logic [DVS_W-1:0]       divisor,
  output logic [DVS_W-1:0]       quotient,
  output logic [DVS_W-1:0]       remainder,
  output logic                   div_by_zero,
  output logic                   overflow
);

  logic [DVS_W:0]   p_reg;
  logic [DVS_W-1:0] qsr_reg;
  logic [DVS_W-1:0] dvs_reg;
  logic [DVS_W-1:0] quotient_reg;
  logic [DVS_W-1:0] remainder_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;
  logic             fits;

  // The next dividend bit enters from the top of the quotient register, which
  // initially holds the low dividend word and fills with quotient bits.
  always_comb begin
    trial = {p_reg[DVS_W-1:0], qsr_reg[DVS_W-1]};
    fits  = (trial >= {1'b0, dvs_reg});
    diff  = trial - {1'b0, dvs_reg};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_reg         <= '0;
      qsr_reg       <= '0;
      dvs_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      if (load) begin
        p_reg   <= {1'b0, dividend[DVD_W-1:DVS_W]};
        qsr_reg <= dividend[DVS_W-1:0];
        dvs_reg <= divisor;
        dbz_reg <= 1'b0;
        ovf_reg <= 1'b0;
      end else if (step) begin
        p_reg   <= fits ? diff : trial;
        qsr_reg <= {qsr_reg[DVS_W-2:0], fits};
      end

      // On an exception no step has run, so qsr_reg still holds dividend[31:0].
      if (commit) begin
        case (exc_code)
          EXC_DBZ: begin
            quotient_reg  <= Q_ALL_ONES;
            remainder_reg <= qsr_reg;
            dbz_reg       <= 1'b1;
          end
          EXC_OVF: begin
            quotient_reg  <= Q_ALL_ONES;
            remainder_reg <= '0;
            ovf_reg       <= 1'b1;
          end
          default: begin
            quotient_reg  <= qsr_reg;
            remainder_reg <= p_reg[DVS_W-1:0];
          end
        endcase
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;

endmodule

// File: rtl/div64x32.sv
// 64-by-32 unsigned restoring divider, one quotient bit per clock, sharing the
// start/busy handshake of the iterative multiplier.
module div64x32
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DVD_W-1:0]  dividend,
  input  logic [DVS_W-1:0]  divisor,
  output logic              busy,
  output logic [DVS_W-1:0]  quotient,
  output logic [DVS_W-1:0]  remainder,
  output logic              div_by_zero,
  output logic              overflow
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  exc_t             exc_reg;
  exc_t             exc_next;
  exc_t             exc_in;

  logic load;
  logic step;
  logic commit;

  assign exc_in = classify(dividend, divisor);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    exc_next   = exc_reg;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          exc_next = exc_in;
          if (exc_in == EXC_NONE) begin
            cnt_next   = CNT_W'(DIV_ITER - 1);
            state_next = RUN;
          end else begin
            cnt_next   = '0;
            state_next = DONE;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_reg == '0)
          state_next = DONE;
        else
          cnt_next = cnt_reg - 1'b1;
      end
      DONE: begin
        commit     = 1'b1;
        exc_next   = EXC_NONE;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        exc_next   = EXC_NONE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      exc_reg   <= EXC_NONE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      exc_reg   <= exc_next;
    end
  end

  assign busy = (state_reg != IDLE);

  div64x32_arith u_arith (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .commit      (commit),
    .exc_code    (exc_reg),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

endmodule

// File: tb/tb_div64x32.sv
// Directed and round-trip bench for div64x32 with a queue of expected results.
module tb_div64x32;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  div64x32 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input logic ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    sb.push_back(e);
  endtask

  // Drive start for one cycle, then scramble the operands to show they were latched.
  task automatic launch(input logic [63:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
  endtask

  task automatic finish_op(input string tag, input int exp_cycles, input int pre);
    int   cnt;
    exp_t e;
    cnt = pre;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_cycles));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard got=empty want=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"},  64'(quotient),    64'(e.q));
      chk({tag, "_r"},  64'(remainder),   64'(e.r));
      chk({tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
      chk({tag, "_ov"}, 64'(overflow),    64'(e.ov));
    end
    $display("op %s: q=%0h r=%0h dz=%0b ov=%0b busy_cycles=%0d",
             tag, quotient, remainder, div_by_zero, overflow, cnt);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [63:0] prod;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy),        64'd0);
    chk("rst_q",    64'(quotient),    64'd0);
    chk("rst_r",    64'(remainder),   64'd0);
    chk("rst_dz",   64'(div_by_zero), 64'd0);
    chk("rst_ov",   64'(overflow),    64'd0);
    reset = 1'b1;

    push_exp(32'd14, 32'd2, 1'b0, 1'b0);
    launch(64'd100, 32'd7);
    finish_op("small", 33, 0);

    push_exp(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    launch(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    finish_op("max", 33, 0);

    push_exp(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
    launch(64'h1234, 32'd0);
    finish_op("zdiv", 1, 0);

    push_exp(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    launch(64'h0000_0005_0000_0000, 32'd5);
    finish_op("ovf", 1, 0);

    // Flags from the overflow above must clear on the next accept.
    push_exp(32'd3, 32'd1, 1'b0, 1'b0);
    launch(64'd10, 32'd3);
    finish_op("clr", 33, 0);

    // A start pulse mid-run must be ignored.
    push_exp(32'd333, 32'd1, 1'b0, 1'b0);
    launch(64'd1000, 32'd3);
    repeat (4) @(negedge clk);
    dividend = 64'd9;
    divisor  = 32'd9;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    finish_op("busy_start", 33, 5);
    @(negedge clk);
    chk("busy_start_idle", 64'(busy), 64'd0);

    // Reset in the middle of a run discards the operation.
    launch(64'd1000, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", 64'(busy),        64'd0);
    chk("midrst_q",    64'(quotient),    64'd0);
    chk("midrst_r",    64'(remainder),   64'd0);
    chk("midrst_dz",   64'(div_by_zero), 64'd0);
    chk("midrst_ov",   64'(overflow),    64'd0);
    @(negedge clk);
    chk("midrst_stay_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = (i % 4 == 3) ? 32'($urandom_range(1, 255)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      r = (i % 2 == 0) ? 32'd0 : ($urandom % b);
      prod = {32'd0, a} * {32'd0, b} + {32'd0, r};
      push_exp(a, r, 1'b0, 1'b0);
      launch(prod, b);
      finish_op($sformatf("rt%0d", i), 33, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div64x32.md
Name: div64x32

Overview:
Iterative 64-by-32 unsigned restoring divider; the inverse companion of the team's 32x32 iterative multiplier.
- Accepts a 64-bit dividend (e.g. a multiplier product) and a 32-bit divisor.
- Returns a 32-bit quotient and a 32-bit remainder, one quotient bit per clock.
- Uses the same start/busy handshake as the multiplier, so both share one controller slot in the datapath.

Parameters:
None. Widths are fixed at 64/32 to pair with the multiplier.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request; sampled only when busy=0
dividend  input  64  unsigned dividend; sampled on accepted start
divisor  input  32  unsigned divisor; sampled on accepted start
busy  output  1  operation in progress
quotient  output  32  result quotient
remainder  output  32  result remainder
div_by_zero  output  1  last operation had divisor==0
overflow  output  1  last operation's quotient did not fit in 32 bits

Behaviour:
- Reset: reset=0 at a rising edge gives the following on the next cycle. Applies in any state, including mid-operation; the in-flight result is discarded.
  - State is IDLE.
  - busy=0; quotient=0; remainder=0; div_by_zero=0; overflow=0.
  - Internal registers and counter are 0.
- States: IDLE, RUN, DONE. busy=1 exactly in RUN and DONE.
- IDLE:
  - start=1 is accepted. Operands are latched, and div_by_zero and overflow are cleared.
  - If divisor==0, go to DONE with the zero-divide flag pending.
  - Else if dividend[63:32] >= divisor, go to DONE with the overflow flag pending.
  - Otherwise load the partial remainder P (33 bits) = {1'b0, dividend[63:32]}, load the quotient shift register with dividend[31:0], set iteration counter = 31, and go to RUN.
- RUN (32 cycles), each cycle:
  - T = {P[31:0], Qsr[31]}.
  - If T >= {1'b0, divisor}, then P = T - divisor and the new quotient bit is 1; else P = T and the bit is 0.
  - Qsr shifts left, inserting the quotient bit at bit 0.
  - The counter decrements. When the counter is 0 this cycle, go to DONE.
  - Invariant: P < divisor always, so P[32] is never set after a subtract.
- DONE (1 cycle): outputs are registered, then go to IDLE.
  - Normal: quotient = Qsr, remainder = P[31:0].
  - Zero-divide: div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=dividend[31:0].
  - Overflow: overflow=1, quotient=32'hFFFF_FFFF, remainder=0.
  - div_by_zero and overflow are never both set. Zero-divide takes priority because 0 <= any high word.
- Latency: start accepted at edge k.
  - Normal: busy=1 for edges k+1..k+33; results are valid from the cycle busy returns to 0.
  - Exception: busy=1 for one cycle; results are valid after it.
- Outputs hold their values until the next DONE or reset. They are not cleared by start; only the flags clear at accept.
- start while busy=1 is ignored; latched operands are unaffected.
- start held high continuously starts back-to-back operations, with one IDLE cycle between them.
- Input operands may change freely after accept.

Decomposition:
- Package div_pkg contains:
  - the state enum typedef (IDLE, RUN, DONE);
  - the localparam DIV_ITER=32;
  - the widths DVD_W=64 and DVS_W=32;
  - the all-ones quotient constant.
- One sub-module: div64x32_arith. It holds P, Qsr, the compare/subtract and the result registers.
  - It is controlled by load, step and commit strobes plus an exception-code input.
- The top module div64x32 keeps the FSM and counter inline.

Test Plan:
- Small case: dividend=100, divisor=7 → quotient=14, remainder=2, div_by_zero=0, overflow=0; busy high for exactly 33 cycles.
- Max case: dividend=64'hFFFF_FFFE_0000_0001, divisor=32'hFFFF_FFFF → quotient=32'hFFFF_FFFF, remainder=0.
- Zero divide: dividend=64'h1234, divisor=0 → div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=32'h1234; busy high for 1 cycle.
- Overflow: dividend=64'h0000_0005_0000_0000, divisor=5 → overflow=1, quotient=32'hFFFF_FFFF, remainder=0; busy high for 1 cycle.
- Robustness:
  - Start an op with 1000/3, then pulse start with 9/9 at RUN cycle 5 → result is still quotient=333, remainder=1.
  - In a second op, drive reset=0 at RUN cycle 10 → the next cycle has busy=0 and all outputs 0.
- Round trip: 200 random (a, b≠0) pairs. Compute the product with the multiplier, divide by b → quotient=a, remainder=0. Adding an offset r<b to the product gives remainder=r.
